sha512_block_sched: RTL
=======================

SHA512_BLOCK_SCHED -- requirements
Module: sha512_block_sched

Interface
REQ-001 SHALL have parameter WR_DELAY, default 6: cycles from issuing round t's reads to the write of W[t].
REQ-002 SHALL have parameter LOAD_LAT, default 2: cycles from rd_addr1 issue to the word on block2ctx.
REQ-003 SHALL have port CLK, input, 1: the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1: command request.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when valid&ready.
REQ-007 SHALL have port cmd_op, input, 2: operation code; 0 BLOCK, 1 SAVE, 2 LOAD, 3 reserved (accepted, no-op, done pulse).
REQ-008 SHALL have port cmd_ctx, input, 1: context; drives address bit 7.
REQ-009 SHALL have port cmd_seq, input, 1: sequence; drives address bit 6 for slots.
REQ-010 SHALL have port cmd_slot, input, 2: save slot 0..3.
REQ-011 SHALL have port cmd_ext, input, 1: BLOCK rounds 0..15 take external input.
REQ-012 SHALL have port cmd_iv, input, 1: LOAD reads IVs (addresses 24..31) instead of a slot.
REQ-013 SHALL have the following datapath-control outputs: external_input_en 1, ctx_save_en 1, mem_wr_en 1, wr_addr 8, rd_addr0 8, rd_addr1 8, W16_R1_rst 1, R0_rst 1, Wt_rst 1.
REQ-014 SHALL have port load_valid, output, 1: block2ctx carries a loaded word this cycle.
REQ-015 SHALL have port done, output, 1: one-cycle pulse on command completion.

Function
REQ-016 SHALL use FSM states IDLE, BLK, SAVE, LOAD, DRAIN; cmd_ready=1 only in IDLE; acceptance latches cmd fields and moves to BLK/SAVE/LOAD, or to DRAIN for op 3.
REQ-017 BLK SHALL run round counter t=0..79, one round per cycle; base=cmd_ctx<<7.
REQ-018 For t<16: rd_addr0=base+t, external_input_en=cmd_ext, R0_rst=1, W16_R1_rst=1.
REQ-019 For t>=16: rd_addr0=base+((t-7) mod 16), rd_addr1=base+((t-15) mod 16), external_input_en=0, R0_rst=0, W16_R1_rst=0.
REQ-020 BLK SHALL assert mem_wr_en with wr_addr=base+(t mod 16) exactly WR_DELAY cycles after round t's issue cycle, for all 80 rounds.
REQ-021 After t=79, SHALL enter DRAIN until the last write issues; done pulses the cycle after the last write; then IDLE.
REQ-022 SAVE SHALL assert ctx_save_en for 8 cycles i=0..7 and mem_wr_en at cycle i+1 with wr_addr=(cmd_ctx<<7)|(cmd_seq<<6)|32+cmd_slot*8+i; done follows the last write.
REQ-023 LOAD SHALL drive rd_addr1=src+i for i=0..7, src=24 if cmd_iv else slot address per REQ-022; load_valid high at cycles i+LOAD_LAT; done with the last load_valid.
REQ-024 Wt_rst SHALL be 1 in IDLE, SAVE, LOAD and 0 from BLK entry until DRAIN exit.
REQ-025 Outside active use, mem_wr_en, ctx_save_en, external_input_en, load_valid and done SHALL be 0; rd/wr addresses SHALL hold 0.
REQ-026 cmd_valid SHALL be ignored while busy; cmd fields SHALL be sampled only at acceptance.
REQ-027 All address arithmetic SHALL be 8-bit; mod-16 offsets never leave the context's 0..15 block region.

Reset
REQ-028 rst SHALL force IDLE; cmd_ready=1, Wt_rst=R0_rst=W16_R1_rst=1; all other outputs 0; counters 0.
REQ-029 rst mid-command SHALL abort at once with no further mem_wr_en; pending delayed writes are discarded.

Structure
REQ-030 Op codes, ROUNDS=80, IV_BASE=24, SLOT_BASE=32 and the address-field layout SHALL live in the shared sha512 header.
REQ-031 The WR_DELAY write path SHALL be a sub-module sha512_wr_delay: a shift register of {en, addr}.

Verification
REQ-032 BLOCK ctx0 ext=1 -> rounds 0..15 external_input_en=1; first mem_wr_en at cycle 6, wr_addr 0; t=16 issues rd_addr0=9, rd_addr1=1; done at cycle 86.
REQ-033 BLOCK ctx1 ext=0 -> rd_addr0=128..143 for t<16; last write wr_addr 143; no write outside 128..143.
REQ-034 SAVE ctx1 seq1 slot2 -> wr_addr 240..247 on cycles 1..8; ctx_save_en cycles 0..7.
REQ-035 LOAD cmd_iv=1 -> rd_addr1 24..31; load_valid cycles 2..9; done at cycle 9.
REQ-036 rst at BLK t=40 -> next cycle IDLE, no mem_wr_en afterwards, cmd_ready=1.
REQ-037 cmd_valid held through BLK -> exactly one command accepted; the second is accepted only after done.

Source files
------------

// File: rtl/sha512_block_sched_pkg.sv
// Shared SHA-512 block scheduler definitions: op codes, round counts and address layout.
package sha512_block_sched_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned CNT_W      = 7;
    localparam int unsigned ROUNDS     = 80;
    localparam int unsigned MSG_WORDS  = 16;
    localparam int unsigned SAVE_WORDS = 8;
    localparam int unsigned IV_BASE    = 24;
    localparam int unsigned SLOT_BASE  = 32;
    localparam int unsigned CTX_BIT    = 7;
    localparam int unsigned SEQ_BIT    = 6;
    localparam int unsigned SLOT_SHIFT = 3;

    typedef enum logic [1:0] {
        OP_BLOCK = 2'd0,
        OP_SAVE  = 2'd1,
        OP_LOAD  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BLK   = 3'd1,
        ST_SAVE  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Command fields captured at acceptance.
    typedef struct packed {
        op_e        op;
        logic       ctx;
        logic       seq;
        logic [1:0] slot;
        logic       ext;
        logic       iv;
    } cmd_t;

    // One entry of the delayed write path.
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
    } wr_req_t;

    // Context base address: ctx selects the upper 128-word half.
    function automatic logic [ADDR_W-1:0] ctx_base(input logic ctx);
        return ADDR_W'(ctx) << CTX_BIT;
    endfunction

    // Message-word address inside the context's 16-word block region.
    function automatic logic [ADDR_W-1:0] blk_addr(input logic ctx, input logic [3:0] off);
        return ctx_base(ctx) | ADDR_W'(off);
    endfunction

    // First address of a save slot.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic ctx, input logic seq,
                                                    input logic [1:0] slot);
        return ctx_base(ctx) | (ADDR_W'(seq) << SEQ_BIT)
             | (ADDR_W'(SLOT_BASE) + (ADDR_W'(slot) << SLOT_SHIFT));
    endfunction

endpackage

// File: rtl/sha512_wr_delay.sv
// Fixed-latency shift register carrying {en, addr} for schedule write-back.
module sha512_wr_delay
    import sha512_block_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 6
) (
    input  logic    CLK,
    input  logic    rst,
    input  wr_req_t req_i,
    output wr_req_t req_o
);

    wr_req_t [DEPTH-1:0] pipe_q;
    wr_req_t [DEPTH-1:0] pipe_d;

    // Shift one stage per cycle.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = req_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline register; reset discards pending writes.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign req_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sha512_block_sched.sv
// SHA-512 message schedule / context save-load sequencer driving the W memory datapath.
module sha512_block_sched
    import sha512_block_sched_pkg::*;
#(
    parameter int unsigned WR_DELAY = 6,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_ctx,
    input  logic              cmd_seq,
    input  logic [1:0]        cmd_slot,
    input  logic              cmd_ext,
    input  logic              cmd_iv,
    output logic              external_input_en,
    output logic              ctx_save_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic              W16_R1_rst,
    output logic              R0_rst,
    output logic              Wt_rst,
    output logic              load_valid,
    output logic              done
);

    localparam logic [CNT_W-1:0] BLK_LAST   = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] MSG_END    = CNT_W'(MSG_WORDS);
    localparam logic [CNT_W-1:0] SAVE_END   = CNT_W'(SAVE_WORDS);
    localparam logic [CNT_W-1:0] SAVE_LAST  = CNT_W'(SAVE_WORDS + 1);
    localparam logic [CNT_W-1:0] LOAD_BEG   = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(SAVE_WORDS - 1 + LOAD_LAT);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WR_DELAY);
    localparam logic [CNT_W-1:0] OFF_W7     = CNT_W'(7);
    localparam logic [CNT_W-1:0] OFF_W15    = CNT_W'(15);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cmd_t              cmd_q, cmd_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              ext_q, ext_d;
    logic              save_q, save_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd0_q, rd0_d;
    logic [ADDR_W-1:0] rd1_q, rd1_d;
    logic              w16_q, w16_d;
    logic              r0_q, r0_d;
    logic              wt_q, wt_d;
    logic              lv_q, lv_d;
    logic              done_q, done_d;

    wr_req_t           blk_req;
    wr_req_t           dly_req;

    sha512_wr_delay #(
        .DEPTH (WR_DELAY)
    ) u_wr_delay (
        .CLK   (CLK),
        .rst   (rst),
        .req_i (blk_req),
        .req_o (dly_req)
    );

    // Next state, then outputs decoded from the next state so every port is a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        cmd_ready_d = 1'b0;
        ext_d       = 1'b0;
        save_d      = 1'b0;
        wr_en_d     = dly_req.en;
        wr_addr_d   = dly_req.addr;
        rd0_d       = '0;
        rd1_d       = '0;
        w16_d       = 1'b1;
        r0_d        = 1'b1;
        wt_d        = 1'b1;
        lv_d        = 1'b0;
        done_d      = 1'b0;
        blk_req     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = '{op: op_e'(cmd_op), ctx: cmd_ctx, seq: cmd_seq,
                              slot: cmd_slot, ext: cmd_ext, iv: cmd_iv};
                    cnt_d = '0;
                    unique case (op_e'(cmd_op))
                        OP_BLOCK: state_d = ST_BLK;
                        OP_SAVE:  state_d = ST_SAVE;
                        OP_LOAD:  state_d = ST_LOAD;
                        default:  state_d = ST_DRAIN;
                    endcase
                end
            end
            ST_BLK: begin
                if (cnt_q == BLK_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAVE: begin
                if (cnt_q == SAVE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == ((cmd_q.op == OP_BLOCK) ? DRAIN_LAST : '0)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        unique case (state_d)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
            end
            ST_BLK: begin
                wt_d         = 1'b0;
                blk_req.en   = 1'b1;
                blk_req.addr = blk_addr(cmd_d.ctx, 4'(cnt_d));
                if (cnt_d < MSG_END) begin
                    rd0_d = blk_addr(cmd_d.ctx, 4'(cnt_d));
                    ext_d = cmd_d.ext;
                end else begin
                    rd0_d = blk_addr(cmd_d.ctx, 4'(cnt_d - OFF_W7));
                    rd1_d = blk_addr(cmd_d.ctx, 4'(cnt_d - OFF_W15));
                    r0_d  = 1'b0;
                    w16_d = 1'b0;
                end
            end
            ST_SAVE: begin
                save_d = (cnt_d < SAVE_END);
                if ((cnt_d != '0) && (cnt_d <= SAVE_END)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = slot_addr(cmd_d.ctx, cmd_d.seq, cmd_d.slot)
                              + ADDR_W'(cnt_d - 1'b1);
                end
                done_d = (cnt_d == SAVE_LAST);
            end
            ST_LOAD: begin
                if (cnt_d < SAVE_END) begin
                    rd1_d = (cmd_d.iv ? ADDR_W'(IV_BASE)
                                      : slot_addr(cmd_d.ctx, cmd_d.seq, cmd_d.slot))
                          + ADDR_W'(cnt_d);
                end
                lv_d   = (cnt_d >= LOAD_BEG) && (cnt_d <= LOAD_LAST);
                done_d = (cnt_d == LOAD_LAST);
            end
            ST_DRAIN: begin
                wt_d   = (cmd_d.op != OP_BLOCK);
                done_d = (cnt_d == ((cmd_d.op == OP_BLOCK) ? DRAIN_LAST : '0));
            end
            default: begin
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
        end
    end

    // Output register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            cmd_ready_q <= 1'b1;
            ext_q       <= 1'b0;
            save_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            rd0_q       <= '0;
            rd1_q       <= '0;
            w16_q       <= 1'b1;
            r0_q        <= 1'b1;
            wt_q        <= 1'b1;
            lv_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            ext_q       <= ext_d;
            save_q      <= save_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
            w16_q       <= w16_d;
            r0_q        <= r0_d;
            wt_q        <= wt_d;
            lv_q        <= lv_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign external_input_en = ext_q;
    assign ctx_save_en       = save_q;
    assign mem_wr_en         = wr_en_q;
    assign wr_addr           = wr_addr_q;
    assign rd_addr0          = rd0_q;
    assign rd_addr1          = rd1_q;
    assign W16_R1_rst        = w16_q;
    assign R0_rst            = r0_q;
    assign Wt_rst            = wt_q;
    assign load_valid        = lv_q;
    assign done              = done_q;

endmodule
